// File: rtl/knight_scan_sequencer.sv
// rtl/knight_scan_sequencer.sv - steps the knight scanner through all directions and accumulates target/capture masks
module knight_scan_sequencer #(
  parameter int SCAN_LATENCY = 1,
  parameter int NUM_DIRS     = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [5:0]   position,
  input  logic [255:0] board,
  input  logic         mover_color,
  output logic         busy,
  output logic         done,
  output logic [63:0]  target_mask,
  output logic [63:0]  capture_mask,
  output logic [3:0]   target_count,
  output logic [255:0] scan_board,
  output logic [5:0]   scan_position,
  output logic [2:0]   scan_direction,
  input  logic [5:0]   scan_near_pos,
  input  logic [2:0]   scan_near_piece
);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, CAPTURE, FINISH} state_t;

  localparam logic [2:0] LAST_DIR  = 3'(NUM_DIRS - 1);
  // Only meaningful when SCAN_LATENCY > 1; the WAIT state is bypassed otherwise.
  localparam logic [1:0] WAIT_LAST = 2'(SCAN_LATENCY - 2);

  state_t     state, state_next;
  logic [2:0] dir;
  logic [1:0] wait_cnt;
  logic       color;
  logic       off_board;
  logic       hit_empty;
  logic       hit_enemy;

  assign scan_direction = dir;

  // Colour comes from the latched snapshot so live board edits cannot leak into a scan.
  always_comb begin
    off_board = (scan_near_pos == scan_position);
    hit_empty = (scan_near_piece == 3'd0);
    hit_enemy = (scan_board[{scan_near_pos, 2'b11}] != color);
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_next = ISSUE;
      end
      ISSUE: begin
        busy       = 1'b1;
        state_next = (SCAN_LATENCY > 1) ? WAIT : CAPTURE;
      end
      WAIT: begin
        busy = 1'b1;
        if (wait_cnt == WAIT_LAST) state_next = CAPTURE;
      end
      CAPTURE: begin
        busy       = 1'b1;
        state_next = (dir == LAST_DIR) ? FINISH : ISSUE;
      end
      FINISH: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      dir           <= 3'd0;
      wait_cnt      <= 2'd0;
      color         <= 1'b0;
      scan_position <= 6'd0;
      scan_board    <= '0;
      target_mask   <= '0;
      capture_mask  <= '0;
      target_count  <= 4'd0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (start) begin
            scan_position <= position;
            scan_board    <= board;
            color         <= mover_color;
            target_mask   <= '0;
            capture_mask  <= '0;
            target_count  <= 4'd0;
            dir           <= 3'd0;
          end
        end
        ISSUE: wait_cnt <= 2'd0;
        WAIT:  wait_cnt <= wait_cnt + 2'd1;
        CAPTURE: begin
          if (!off_board && (hit_empty || hit_enemy)) begin
            target_mask[scan_near_pos] <= 1'b1;
            target_count               <= target_count + 4'd1;
            if (!hit_empty) capture_mask[scan_near_pos] <= 1'b1;
          end
          if (dir != LAST_DIR) dir <= dir + 3'd1;
        end
        default: ;
      endcase
    end
  end

endmodule
